pc_branch_ctrl: RTL and testbench
=================================

# pc_branch_ctrl

Program-counter and branch-resolution unit for the RV32I core. Owns the fetch PC register, turns EX-stage branch/jump information plus the branch comparator's less/equal flags into a taken decision, redirects fetch and flushes younger stages on taken control transfers, and traps misaligned targets. Sits directly downstream of the branch comparator and drives its signed/unsigned select.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- i_clk  in  1  core clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_stall  in  1  hold fetch PC (hazard stall)
- i_ex_valid  in  1  EX-stage instruction valid
- i_ex_pc  in  32  PC of EX instruction
- i_ex_imm  in  32  sign-extended immediate
- i_ex_rs1_data  in  32  rs1 operand (JALR base)
- i_is_branch / i_is_jal / i_is_jalr  in  1 each  instruction class, one-hot or all zero
- i_br_type  in  3  funct3 of branch
- i_br_less  in  1  comparator rs1<rs2
- i_br_equal  in  1  comparator rs1==rs2
- i_trap_ack  in  1  trap handler accepts misalign trap
- i_trap_vec  in  32  PC to resume at on i_trap_ack
- o_br_un  out  1  comparator mode, 1 = unsigned (BLTU/BGEU)
- o_pc  out  32  fetch PC (register)
- o_pc_four  out  32  o_pc + 4
- o_link  out  32  i_ex_pc + 4 for JAL/JALR writeback
- o_redirect  out  1  fetch redirected this cycle
- o_flush  out  1  kill IF/ID and ID/EX at next edge
- o_misalign  out  1  misaligned-target trap pending (register)
- o_cnt_branch, o_cnt_taken  out  32 each  only with PC_BR_PERF_EN

## Operation
- Taken: BEQ eq; BNE !eq; BLT/BLTU less; BGE/BGEU !less; funct3 010/011 never taken; JAL/JALR always taken.
- o_br_un = i_br_type[1] (combinational, independent of valid).
- Target: branch/JAL = i_ex_pc + i_ex_imm; JALR = (i_ex_rs1_data + i_ex_imm) & ~32'h1; all mod 2^32.
- Misaligned: taken and target[1:0] != 0.
- FSM RUN/TRAP, reset RUN.
- RUN, i_ex_valid & taken & aligned: o_redirect=1, o_flush=1, PC <= target regardless of i_stall.
- RUN, i_ex_valid & taken & misaligned: no redirect, o_flush=1, PC holds, o_misalign <= 1, -> TRAP.
- RUN, otherwise: PC <= PC+4 unless i_stall (hold). PC wraps FFFF_FFFC -> 0000_0000.
- TRAP: o_flush=1 every cycle, PC holds, EX inputs ignored; i_trap_ack -> PC <= i_trap_vec, o_misalign <= 0, -> RUN. i_trap_ack ignored in RUN.
- Not taken: no flush (static not-taken fetch).

## Timing
- Decision, o_redirect, o_flush, o_br_un, o_link combinational in EX cycle; new PC visible one cycle after redirect edge.
- Branch penalty: 2 flushed instructions.
- Reset mid-operation: o_pc=RESET_PC, o_misalign=0, FSM RUN, counters 0, asynchronously; combinational outputs follow inputs with state RUN.
- Redirect + stall same cycle: redirect wins.
- Trap ack: RUN resumes at i_trap_vec one cycle later; EX instruction of the ack cycle is ignored.

## Configuration
- PC_BR_PERF_EN defined: o_cnt_branch increments on every i_ex_valid & i_is_branch in RUN; o_cnt_taken on those taken (including misaligned); both wrap 2^32-1 -> 0.
- Undefined: counter ports and registers absent.

## Structure
- Package pc_branch_pkg: funct3 localparams (BEQ..BGEU), FSM state enum, default RESET_PC.
- Sub-module br_decide: combinational taken/o_br_un from class, funct3, less, equal.

## Test plan
- Reset release with RESET_PC=32'h100, no stall, 3 cycles -> o_pc 100, 104, 108; o_misalign=0.
- BLTU at ex_pc=0x200, imm=0x40, less=1 -> o_br_un=1, o_redirect=1, o_flush=1, next o_pc=0x240; same with less=0 -> no flush, PC+4.
- JALR rs1=0x1001, imm=0x3 -> target 0x1004, o_link=ex_pc+4; rs1=0x1001, imm=0x1 -> target 0x1002 misaligned, o_misalign=1, TRAP, PC held, o_flush held.
- In TRAP pulse i_trap_ack with trap_vec=0x80 -> o_pc=0x80 next cycle, o_misalign=0, normal fetch resumes.
- BEQ taken with i_stall=1 same cycle -> PC loads target; stall alone -> PC holds; PC at FFFF_FFFC -> wraps to 0.
- PC_BR_PERF_EN: 5 branches, 3 taken -> cnt_branch=5, cnt_taken=3; preload-by-force 32'hFFFF_FFFF + 1 branch -> 0.

Source files
------------

// File: rtl/pc_branch_pkg.sv
// Shared definitions for the fetch-PC / branch-resolution unit: branch funct3
// codes, the RUN/TRAP state encoding and the default reset PC.
package pc_branch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pc_branch_ctrl_br_decide.sv
// Combinational taken decision from instruction class, funct3 and the
// comparator flags; also selects signed/unsigned comparator mode.
module br_decide
    import pc_branch_pkg::*;
(
    input  logic       i_is_branch,
    input  logic       i_is_jal,
    input  logic       i_is_jalr,
    input  logic [2:0] i_br_type,
    input  logic       i_br_less,
    input  logic       i_br_equal,
    output logic       o_taken,
    output logic       o_br_un
);

    logic br_cond;

    assign o_br_un = i_br_type[1];

    // funct3 010/011 are not branch encodings and are never taken.
    always_comb begin
        br_cond = 1'b0;
        case (i_br_type)
            F3_BEQ:  br_cond = i_br_equal;
            F3_BNE:  br_cond = ~i_br_equal;
            F3_BLT:  br_cond = i_br_less;
            F3_BGE:  br_cond = ~i_br_less;
            F3_BLTU: br_cond = i_br_less;
            F3_BGEU: br_cond = ~i_br_less;
            default: br_cond = 1'b0;
        endcase
    end

    assign o_taken = i_is_jal | i_is_jalr | (i_is_branch & br_cond);

endmodule

// File: rtl/pc_branch_ctrl.sv
// Fetch PC register, taken-branch redirect/flush and misaligned-target trap.
// Optional performance counters are built when PC_BR_PERF_EN is defined.
module pc_branch_ctrl
    import pc_branch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_ex_valid,
    input  logic [31:0] i_ex_pc,
    input  logic [31:0] i_ex_imm,
    input  logic [31:0] i_ex_rs1_data,
    input  logic        i_is_branch,
    input  logic        i_is_jal,
    input  logic        i_is_jalr,
    input  logic [2:0]  i_br_type,
    input  logic        i_br_less,
    input  logic        i_br_equal,
    input  logic        i_trap_ack,
    input  logic [31:0] i_trap_vec,
    output logic        o_br_un,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_four,
    output logic [31:0] o_link,
    output logic        o_redirect,
    output logic        o_flush,
    output logic        o_misalign,
`ifdef PC_BR_PERF_EN
    output logic [31:0] o_cnt_branch,
    output logic [31:0] o_cnt_taken,
`endif
    output pc_state_e   o_dbg_state
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        misalign_q, misalign_d;

    logic        taken;
    logic        ex_taken;
    logic [31:0] target;
    logic        target_misaligned;

    br_decide u_br_decide (
        .i_is_branch (i_is_branch),
        .i_is_jal    (i_is_jal),
        .i_is_jalr   (i_is_jalr),
        .i_br_type   (i_br_type),
        .i_br_less   (i_br_less),
        .i_br_equal  (i_br_equal),
        .o_taken     (taken),
        .o_br_un     (o_br_un)
    );

    // JALR clears bit 0, so only bit 1 can flag a misaligned JALR target.
    always_comb begin
        if (i_is_jalr) begin
            target = (i_ex_rs1_data + i_ex_imm) & ~32'h1;
        end else begin
            target = i_ex_pc + i_ex_imm;
        end
    end

    assign target_misaligned = (target[1:0] != 2'b00);
    assign ex_taken          = i_ex_valid & taken;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (ex_taken && target_misaligned) begin
                    state_d = ST_TRAP;
                end
            end
            ST_TRAP: begin
                if (i_trap_ack) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Output logic
    always_comb begin
        o_redirect = 1'b0;
        o_flush    = 1'b0;
        case (state_q)
            ST_RUN: begin
                o_redirect = ex_taken & ~target_misaligned;
                o_flush    = ex_taken;
            end
            ST_TRAP: begin
                o_flush = 1'b1;
            end
            default: begin
                o_redirect = 1'b0;
                o_flush    = 1'b0;
            end
        endcase
    end

    // A redirect overrides a concurrent stall; a misaligned target freezes the PC.
    always_comb begin
        pc_d       = pc_q;
        misalign_d = misalign_q;
        case (state_q)
            ST_RUN: begin
                if (ex_taken && !target_misaligned) begin
                    pc_d = target;
                end else if (ex_taken && target_misaligned) begin
                    misalign_d = 1'b1;
                end else if (!i_stall) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            ST_TRAP: begin
                if (i_trap_ack) begin
                    pc_d       = i_trap_vec;
                    misalign_d = 1'b0;
                end
            end
            default: begin
                pc_d       = pc_q;
                misalign_d = misalign_q;
            end
        endcase
    end

    assign o_pc        = pc_q;
    assign o_pc_four   = pc_q + 32'd4;
    assign o_link      = i_ex_pc + 32'd4;
    assign o_misalign  = misalign_q;
    assign o_dbg_state = state_q;

`ifdef PC_BR_PERF_EN
    logic [31:0] cnt_branch_q, cnt_branch_d;
    logic [31:0] cnt_taken_q, cnt_taken_d;
    logic        count_branch;

    assign count_branch = (state_q == ST_RUN) & i_ex_valid & i_is_branch;

    always_comb begin
        cnt_branch_d = cnt_branch_q;
        cnt_taken_d  = cnt_taken_q;
        if (count_branch) begin
            cnt_branch_d = cnt_branch_q + 32'd1;
            if (taken) begin
                cnt_taken_d = cnt_taken_q + 32'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_branch_q <= 32'd0;
            cnt_taken_q  <= 32'd0;
        end else begin
            cnt_branch_q <= cnt_branch_d;
            cnt_taken_q  <= cnt_taken_d;
        end
    end

    assign o_cnt_branch = cnt_branch_q;
    assign o_cnt_taken  = cnt_taken_q;
`endif

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Directed bench for pc_branch_ctrl (RESET_PC = 0x100); counter checks are
// compiled in when PC_BR_PERF_EN is defined.
module tb_pc_branch_ctrl;
    import pc_branch_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_rs1;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic [2:0]  br_type;
    logic        br_less;
    logic        br_equal;
    logic        trap_ack;
    logic [31:0] trap_vec;
    logic        br_un;
    logic [31:0] pc;
    logic [31:0] pc_four;
    logic [31:0] link;
    logic        redirect;
    logic        flush;
    logic        misalign;
    pc_state_e   dbg_state;
`ifdef PC_BR_PERF_EN
    logic [31:0] cnt_branch;
    logic [31:0] cnt_taken;
`endif

    int checks = 0;
    int errors = 0;

    pc_branch_ctrl #(.RESET_PC(32'h0000_0100)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_stall       (stall),
        .i_ex_valid    (ex_valid),
        .i_ex_pc       (ex_pc),
        .i_ex_imm      (ex_imm),
        .i_ex_rs1_data (ex_rs1),
        .i_is_branch   (is_branch),
        .i_is_jal      (is_jal),
        .i_is_jalr     (is_jalr),
        .i_br_type     (br_type),
        .i_br_less     (br_less),
        .i_br_equal    (br_equal),
        .i_trap_ack    (trap_ack),
        .i_trap_vec    (trap_vec),
        .o_br_un       (br_un),
        .o_pc          (pc),
        .o_pc_four     (pc_four),
        .o_link        (link),
        .o_redirect    (redirect),
        .o_flush       (flush),
        .o_misalign    (misalign),
`ifdef PC_BR_PERF_EN
        .o_cnt_branch  (cnt_branch),
        .o_cnt_taken   (cnt_taken),
`endif
        .o_dbg_state   (dbg_state)
    );

    // Clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: inputs change 2 time units after a rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_ex();
        ex_valid  = 1'b0;
        ex_pc     = 32'h0;
        ex_imm    = 32'h0;
        ex_rs1    = 32'h0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        br_type   = 3'b000;
        br_less   = 1'b0;
        br_equal  = 1'b0;
        trap_ack  = 1'b0;
        trap_vec  = 32'h0;
    endtask

    task automatic drive_branch(input logic [2:0] f3, input logic less, input logic eq,
                                input logic [31:0] epc, input logic [31:0] imm);
        idle_ex();
        ex_valid  = 1'b1;
        is_branch = 1'b1;
        br_type   = f3;
        br_less   = less;
        br_equal  = eq;
        ex_pc     = epc;
        ex_imm    = imm;
    endtask

    task automatic drive_jalr(input logic [31:0] epc, input logic [31:0] rs1, input logic [31:0] imm);
        idle_ex();
        ex_valid = 1'b1;
        is_jalr  = 1'b1;
        ex_pc    = epc;
        ex_rs1   = rs1;
        ex_imm   = imm;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        idle_ex();
        #11;
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL rst_pc: got %h exp %h", pc, 32'h100); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign: got %b exp 0", misalign); end
        checks++; if (flush !== 1'b0 || redirect !== 1'b0) begin errors++; $display("FAIL rst_flush: got %b/%b exp 0/0", flush, redirect); end
        checks++; if (dbg_state !== ST_RUN) begin errors++; $display("FAIL rst_state: got %0d exp %0d", dbg_state, ST_RUN); end
        #1 rst_n = 1'b1;
        step();
        checks++; if (pc !== 32'h104) begin errors++; $display("FAIL rst_pc1: got %h exp %h", pc, 32'h104); end
        step();
        checks++; if (pc !== 32'h108) begin errors++; $display("FAIL rst_pc2: got %h exp %h", pc, 32'h108); end
        checks++; if (pc_four !== 32'h10C) begin errors++; $display("FAIL rst_pc_four: got %h exp %h", pc_four, 32'h10C); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign2: got %b exp 0", misalign); end
    endtask

    task automatic test_bltu();
        drive_branch(F3_BLTU, 1'b1, 1'b0, 32'h200, 32'h40);
        #1;
        checks++; if (br_un !== 1'b1) begin errors++; $display("FAIL bltu_un: got %b exp 1", br_un); end
        checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL bltu_redirect: got %b exp 1", redirect); end
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL bltu_flush: got %b exp 1", flush); end
        step();
        checks++; if (pc !== 32'h240) begin errors++; $display("FAIL bltu_pc: got %h exp %h", pc, 32'h240); end
        drive_branch(F3_BLTU, 1'b0, 1'b0, 32'h200, 32'h40);
        #1;
        checks++; if (redirect !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL bltu_nt: got %b/%b exp 0/0", redirect, flush); end
        step();
        checks++; if (pc !== 32'h244) begin errors++; $display("FAIL bltu_nt_pc: got %h exp %h", pc, 32'h244); end
    endtask

    task automatic test_jalr_trap();
        drive_jalr(32'h300, 32'h1001, 32'h3);
        #1;
        checks++; if (redirect !== 1'b1 || flush !== 1'b1) begin errors++; $display("FAIL jalr_redir: got %b/%b exp 1/1", redirect, flush); end
        checks++; if (link !== 32'h304) begin errors++; $display("FAIL jalr_link: got %h exp %h", link, 32'h304); end
        step();
        checks++; if (pc !== 32'h1004) begin errors++; $display("FAIL jalr_pc: got %h exp %h", pc, 32'h1004); end
        drive_jalr(32'h300, 32'h1001, 32'h1);
        #1;
        checks++; if (redirect !== 1'b0 || flush !== 1'b1) begin errors++; $display("FAIL jalr_mis_comb: got %b/%b exp 0/1", redirect, flush); end
        step();
        idle_ex();
        #1;
        checks++; if (pc !== 32'h1004) begin errors++; $display("FAIL trap_pc: got %h exp %h", pc, 32'h1004); end
        checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL trap_misalign: got %b exp 1", misalign); end
        checks++; if (dbg_state !== ST_TRAP) begin errors++; $display("FAIL trap_state: got %0d exp %0d", dbg_state, ST_TRAP); end
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL trap_flush: got %b exp 1", flush); end
        // EX instruction while trapped must be ignored.
        is_jal = 1'b1; ex_valid = 1'b1; ex_pc = 32'h700; ex_imm = 32'h20;
        #1;
        checks++; if (redirect !== 1'b0 || flush !== 1'b1) begin errors++; $display("FAIL trap_ex_ignored: got %b/%b exp 0/1", redirect, flush); end
        step();
        checks++; if (pc !== 32'h1004) begin errors++; $display("FAIL trap_hold: got %h exp %h", pc, 32'h1004); end
    endtask

    task automatic test_trap_ack();
        trap_ack = 1'b1;
        trap_vec = 32'h80;
        step();
        idle_ex();
        #1;
        checks++; if (pc !== 32'h80) begin errors++; $display("FAIL ack_pc: got %h exp %h", pc, 32'h80); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL ack_misalign: got %b exp 0", misalign); end
        checks++; if (flush !== 1'b0 || dbg_state !== ST_RUN) begin errors++; $display("FAIL ack_run: got flush %b state %0d exp 0/%0d", flush, dbg_state, ST_RUN); end
        step();
        checks++; if (pc !== 32'h84) begin errors++; $display("FAIL ack_resume: got %h exp %h", pc, 32'h84); end
        trap_ack = 1'b1;
        trap_vec = 32'h500;
        step();
        idle_ex();
        checks++; if (pc !== 32'h88) begin errors++; $display("FAIL ack_in_run: got %h exp %h", pc, 32'h88); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        drive_branch(F3_BEQ, 1'b0, 1'b1, 32'h400, 32'hFFFF_FFF8);
        #1;
        checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL beq_stall_redir: got %b exp 1", redirect); end
        step();
        idle_ex();
        checks++; if (pc !== 32'h3F8) begin errors++; $display("FAIL beq_stall_pc: got %h exp %h", pc, 32'h3F8); end
        step();
        checks++; if (pc !== 32'h3F8) begin errors++; $display("FAIL stall_hold: got %h exp %h", pc, 32'h3F8); end
        stall = 1'b0;
        step();
        checks++; if (pc !== 32'h3FC) begin errors++; $display("FAIL stall_release: got %h exp %h", pc, 32'h3FC); end
    endtask

    task automatic test_branch_types();
        logic [2:0] f3_t  [10] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b011};
        logic       less_t[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       eq_t  [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic       tkn_t [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       un_t  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 10; i++) begin
            drive_branch(f3_t[i], less_t[i], eq_t[i], 32'h600, 32'h10);
            #1;
            checks++; if (redirect !== tkn_t[i]) begin errors++; $display("FAIL br_type_taken[%0d]: got %b exp %b", i, redirect, tkn_t[i]); end
            checks++; if (br_un !== un_t[i]) begin errors++; $display("FAIL br_type_un[%0d]: got %b exp %b", i, br_un, un_t[i]); end
            step();
        end
        idle_ex();
    endtask

    task automatic test_wrap();
        idle_ex();
        ex_valid = 1'b1;
        is_jal   = 1'b1;
        ex_pc    = 32'h0;
        ex_imm   = 32'hFFFF_FFFC;
        #1;
        checks++; if (link !== 32'h4) begin errors++; $display("FAIL jal_link: got %h exp %h", link, 32'h4); end
        step();
        idle_ex();
        checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pre: got %h exp %h", pc, 32'hFFFF_FFFC); end
        checks++; if (pc_four !== 32'h0) begin errors++; $display("FAIL wrap_pc_four: got %h exp %h", pc_four, 32'h0); end
        step();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h exp %h", pc, 32'h0); end
    endtask

    task automatic test_reset_mid();
        drive_jalr(32'h0, 32'h2000, 32'h2);
        step();
        idle_ex();
        #1;
        checks++; if (dbg_state !== ST_TRAP) begin errors++; $display("FAIL mid_pre_trap: got %0d exp %0d", dbg_state, ST_TRAP); end
        rst_n = 1'b0;
        #1;
        checks++; if (pc !== 32'h100 || misalign !== 1'b0) begin errors++; $display("FAIL mid_reset: got pc %h mis %b exp 100/0", pc, misalign); end
        checks++; if (dbg_state !== ST_RUN || flush !== 1'b0) begin errors++; $display("FAIL mid_reset_state: got %0d/%b exp %0d/0", dbg_state, flush, ST_RUN); end
        rst_n = 1'b1;
        step();
        checks++; if (pc !== 32'h104) begin errors++; $display("FAIL mid_resume: got %h exp %h", pc, 32'h104); end
    endtask

`ifdef PC_BR_PERF_EN
    task automatic test_perf();
        logic [2:0] f3_t  [5] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110};
        checks++; if (cnt_branch !== 32'h0 || cnt_taken !== 32'h0) begin errors++; $display("FAIL perf_reset: got %h/%h exp 0/0", cnt_branch, cnt_taken); end
        for (int i = 0; i < 5; i++) begin
            drive_branch(f3_t[i], 1'b1, 1'b1, 32'h800, 32'h8);
            step();
        end
        idle_ex();
        checks++; if (cnt_branch !== 32'd5) begin errors++; $display("FAIL perf_branch: got %0d exp 5", cnt_branch); end
        checks++; if (cnt_taken !== 32'd3) begin errors++; $display("FAIL perf_taken: got %0d exp 3", cnt_taken); end
        force dut.cnt_branch_q = 32'hFFFF_FFFF;
        force dut.cnt_taken_q  = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_branch_q;
        release dut.cnt_taken_q;
        drive_branch(F3_BEQ, 1'b0, 1'b1, 32'h800, 32'h8);
        step();
        idle_ex();
        checks++; if (cnt_branch !== 32'h0 || cnt_taken !== 32'h0) begin errors++; $display("FAIL perf_wrap: got %h/%h exp 0/0", cnt_branch, cnt_taken); end
    endtask
`endif

    initial begin
        test_reset();
        test_bltu();
        test_jalr_trap();
        test_trap_ack();
        test_stall();
        test_branch_types();
        test_wrap();
        test_reset_mid();
`ifdef PC_BR_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
